// File: rtl/tile_scheduler_writeback_if.sv
// ----------------------------------------------------------------------------
// tile_scheduler_writeback_if
// Bundles the frame control, rasterizer handshake and framebuffer write bus of
// the tile scheduler.
//   master : the scheduler (drives frameDone/busy, tile requests, SRAM beats)
//   slave  : the environment (frame requester, rasterizer, SRAM controller)
// Signals:
//   frameStart, frameDone, busy            frame control
//   startRasterizing, doneRasterizing      rasterizer handshake
//   rasterxOffset, rasteryOffset           pixel origin of requested tile
//   rasterTileID                           colour buffer the rasterizer fills
//   cBufferTile0/1[x][y]                   rasterizer colour tiles
//   sramAddr, sramData, sramWe, sramReady  framebuffer write beat
// ----------------------------------------------------------------------------
interface tile_scheduler_writeback_if #(
  parameter int tileDim  = 4,
  parameter int addrBits = 19
);
  logic                frameStart;
  logic                frameDone;
  logic                busy;
  logic                startRasterizing;
  logic                doneRasterizing;
  logic [9:0]          rasterxOffset;
  logic [9:0]          rasteryOffset;
  logic                rasterTileID;
  logic [15:0]         cBufferTile0 [tileDim][tileDim];
  logic [15:0]         cBufferTile1 [tileDim][tileDim];
  logic [addrBits-1:0] sramAddr;
  logic [15:0]         sramData;
  logic                sramWe;
  logic                sramReady;

  modport master (
    input  frameStart, doneRasterizing, cBufferTile0, cBufferTile1, sramReady,
    output frameDone, busy, startRasterizing, rasterxOffset, rasteryOffset,
           rasterTileID, sramAddr, sramData, sramWe
  );

  modport slave (
    output frameStart, doneRasterizing, cBufferTile0, cBufferTile1, sramReady,
    input  frameDone, busy, startRasterizing, rasterxOffset, rasteryOffset,
           rasterTileID, sramAddr, sramData, sramWe
  );
endinterface

// File: rtl/tile_scheduler_writeback.sv
// ----------------------------------------------------------------------------
// tile_scheduler_writeback
// Walks a frame tile by tile in raster order, asks the rasterizer to fill one
// of two ping-pong colour buffers, and streams each finished buffer into the
// framebuffer while the rasterizer works on the next tile.
// Ports:
//   BOARD_CLK      sole clock, rising edge
//   BOARD_RESET_N  asynchronous active-low reset
//   bus            tile_scheduler_writeback_if.master (frame control,
//                  rasterizer handshake, SRAM write beat)
// ----------------------------------------------------------------------------
module tile_scheduler_writeback #(
  parameter int tileDim  = 4,
  parameter int screenW  = 640,
  parameter int screenH  = 480,
  parameter int addrBits = 19
) (
  input  logic                        BOARD_CLK,
  input  logic                        BOARD_RESET_N,
  tile_scheduler_writeback_if.master  bus
);

  localparam int             CW        = (tileDim > 1) ? $clog2(tileDim) : 1;
  localparam logic [9:0]     LAST_X    = 10'(screenW - tileDim);
  localparam logic [9:0]     LAST_Y    = 10'(screenH - tileDim);
  localparam logic [9:0]     TILE_STEP = 10'(tileDim);
  localparam logic [CW-1:0]  PMAX      = CW'(tileDim - 1);

  // R_DRAIN is the idle-pending-drain state: last tile handed off, waiting
  // for its writeback to finish before frameDone.
  typedef enum logic [2:0] {R_IDLE, R_REQ, R_RELEASE, R_HANDOFF, R_DRAIN} r_state_e;
  typedef enum logic {W_IDLE, W_WRITE} w_state_e;

  r_state_e      r_state_q, r_state_d;
  logic [9:0]    tile_x_q, tile_x_d;
  logic [9:0]    tile_y_q, tile_y_d;
  logic          tile_id_q, tile_id_d;

  w_state_e      w_state_q, w_state_d;
  logic [9:0]    wb_x_q, wb_x_d;
  logic [9:0]    wb_y_q, wb_y_d;
  logic          wb_buf_q, wb_buf_d;
  logic [CW-1:0] px_q, px_d;
  logic [CW-1:0] py_q, py_d;

  logic          wb_start;
  logic          w_idle;
  logic          last_tile;
  logic          beat_acc;
  logic [31:0]   addr_full;
  logic [15:0]   pix;

  assign w_idle    = (w_state_q == W_IDLE);
  assign last_tile = (tile_x_q == LAST_X) && (tile_y_q == LAST_Y);
  assign beat_acc  = (w_state_q == W_WRITE) && bus.sramReady;

  // State registers
  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      r_state_q <= R_IDLE;
      tile_x_q  <= '0;
      tile_y_q  <= '0;
      tile_id_q <= 1'b0;
      w_state_q <= W_IDLE;
      wb_x_q    <= '0;
      wb_y_q    <= '0;
      wb_buf_q  <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      r_state_q <= r_state_d;
      tile_x_q  <= tile_x_d;
      tile_y_q  <= tile_y_d;
      tile_id_q <= tile_id_d;
      w_state_q <= w_state_d;
      wb_x_q    <= wb_x_d;
      wb_y_q    <= wb_y_d;
      wb_buf_q  <= wb_buf_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  // Raster FSM next state. The handoff only fires once the writeback engine
  // is idle, so the buffer being drained is never the one being refilled.
  always_comb begin
    r_state_d = r_state_q;
    tile_x_d  = tile_x_q;
    tile_y_d  = tile_y_q;
    tile_id_d = tile_id_q;
    wb_start  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (bus.frameStart) begin
          r_state_d = R_REQ;
          tile_x_d  = '0;
          tile_y_d  = '0;
          tile_id_d = 1'b0;
        end
      end
      R_REQ:     if (bus.doneRasterizing)  r_state_d = R_RELEASE;
      R_RELEASE: if (!bus.doneRasterizing) r_state_d = R_HANDOFF;
      R_HANDOFF: begin
        if (w_idle) begin
          wb_start = 1'b1;
          if (last_tile) begin
            r_state_d = R_DRAIN;
          end else begin
            r_state_d = R_REQ;
            tile_id_d = ~tile_id_q;
            if (tile_x_q == LAST_X) begin
              tile_x_d = '0;
              tile_y_d = tile_y_q + TILE_STEP;
            end else begin
              tile_x_d = tile_x_q + TILE_STEP;
            end
          end
        end
      end
      R_DRAIN:   if (w_idle) r_state_d = R_IDLE;
      default:   r_state_d = R_IDLE;
    endcase
  end

  // Writeback FSM next state: px fastest, then py; counters only move on an
  // accepted beat so a stalled beat is held unchanged.
  always_comb begin
    w_state_d = w_state_q;
    wb_x_d    = wb_x_q;
    wb_y_d    = wb_y_q;
    wb_buf_d  = wb_buf_q;
    px_d      = px_q;
    py_d      = py_q;
    case (w_state_q)
      W_IDLE: begin
        if (wb_start) begin
          w_state_d = W_WRITE;
          wb_x_d    = tile_x_q;
          wb_y_d    = tile_y_q;
          wb_buf_d  = tile_id_q;
          px_d      = '0;
          py_d      = '0;
        end
      end
      W_WRITE: begin
        if (beat_acc) begin
          if (px_q == PMAX) begin
            px_d = '0;
            if (py_q == PMAX) w_state_d = W_IDLE;
            else              py_d = py_q + CW'(1);
          end else begin
            px_d = px_q + CW'(1);
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Outputs. Address and data are forced to zero outside W_WRITE so that
  // every output reads zero while reset is asserted.
  always_comb begin
    addr_full = (32'(wb_y_q) + 32'(py_q)) * 32'(screenW) + 32'(wb_x_q) + 32'(px_q);
    pix       = wb_buf_q ? bus.cBufferTile1[px_q][py_q] : bus.cBufferTile0[px_q][py_q];
    bus.startRasterizing = (r_state_q == R_REQ);
    bus.busy             = (r_state_q != R_IDLE);
    bus.frameDone        = (r_state_q == R_DRAIN) && w_idle;
    bus.rasterxOffset    = tile_x_q;
    bus.rasteryOffset    = tile_y_q;
    bus.rasterTileID     = tile_id_q;
    bus.sramWe           = (w_state_q == W_WRITE);
    bus.sramAddr         = bus.sramWe ? addr_full[addrBits-1:0] : '0;
    bus.sramData         = bus.sramWe ? pix : 16'h0000;
  end

endmodule

// File: tb/tb_tile_scheduler_writeback.sv
module tb_tile_scheduler_writeback;
  localparam int T  = 4;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AB = 19;
  localparam int TX = W / T;
  localparam int NT = (W / T) * (H / T);
  localparam int NB = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_scheduler_writeback_if #(.tileDim(T), .addrBits(AB)) bus();

  tile_scheduler_writeback #(.tileDim(T), .screenW(W), .screenH(H), .addrBits(AB)) dut (
    .BOARD_CLK    (clk),
    .BOARD_RESET_N(rst_n),
    .bus          (bus)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    nchecks++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { int unsigned addr; int unsigned data; } beat_t;
  beat_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int req_total = 0, req_base = 0;
  int ready_mode = 0;
  bit pattern_mode = 0;
  bit log_en = 0;
  int log_n = 0;
  int unsigned log_addr [NB];
  int unsigned log_data [NB];

  // SRAM ready driver
  bit tg = 1'b0;
  always begin
    @(posedge clk); #1;
    tg = ~tg;
    case (ready_mode)
      0:       bus.sramReady = 1'b1;
      1:       bus.sramReady = tg;
      default: bus.sramReady = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Rasterizer model: fills the requested buffer and records the beats the
  // framebuffer must later receive for that tile.
  bit ras_active = 0;
  int ras_cnt = 0;
  int rk = 0;
  int unsigned rx = 0, ry = 0;
  logic [9:0] cap_x, cap_y;
  logic cap_id;
  logic [15:0] tile_v [T][T];
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      bus.doneRasterizing = 1'b0;
      ras_active = 0;
    end else if (bus.startRasterizing && !bus.doneRasterizing) begin
      if (!ras_active) begin
        rk = req_total - req_base;
        rx = (rk % TX) * T;
        ry = (rk / TX) * T;
        chk(rk < NT, "req_count", rk, NT - 1);
        chk(bus.rasterxOffset == 10'(rx), "req_x", bus.rasterxOffset, rx);
        chk(bus.rasteryOffset == 10'(ry), "req_y", bus.rasteryOffset, ry);
        chk(bus.rasterTileID == 1'(rk % 2), "req_id", bus.rasterTileID, rk % 2);
        // The tile before last must be fully written before a new request.
        chk(exp_q.size() <= T * T, "handoff_wait", exp_q.size(), T * T);
        cap_x = bus.rasterxOffset; cap_y = bus.rasteryOffset; cap_id = bus.rasterTileID;
        req_total++;
        ras_active = 1;
        ras_cnt = pattern_mode ? 5 : $urandom_range(1, 8);
      end else begin
        chk(bus.rasterxOffset == cap_x && bus.rasteryOffset == cap_y && bus.rasterTileID == cap_id,
            "req_stable", {bus.rasterxOffset, bus.rasteryOffset}, {cap_x, cap_y});
        ras_cnt--;
        if (ras_cnt == 0) begin
          for (int px = 0; px < T; px++)
            for (int py = 0; py < T; py++) begin
              tile_v[px][py] = pattern_mode ? 16'(16'h0100 + 4 * py + px) : 16'($urandom);
              if (rk % 2 == 1) bus.cBufferTile1[px][py] = tile_v[px][py];
              else             bus.cBufferTile0[px][py] = tile_v[px][py];
            end
          for (int py = 0; py < T; py++)
            for (int px = 0; px < T; px++)
              exp_q.push_back('{addr: (ry + py) * W + rx + px, data: tile_v[px][py]});
          bus.doneRasterizing = 1'b1;
        end
      end
    end else if (!bus.startRasterizing && bus.doneRasterizing) begin
      bus.doneRasterizing = 1'b0;
      ras_active = 0;
    end
  end

  // Compare process
  int acc_total = 0, done_total = 0, last_acc_cyc = -10, bi = 0;
  bit prev_stall = 0, prev_done = 0;
  logic [AB-1:0] prev_addr;
  logic [15:0] prev_data;
  beat_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
      prev_done = 0;
      bi = 0;
    end else begin
      if (prev_stall) begin
        chk(bus.sramWe == 1'b1, "stall_we", bus.sramWe, 1);
        chk(bus.sramAddr == prev_addr, "stall_addr", bus.sramAddr, prev_addr);
        chk(bus.sramData == prev_data, "stall_data", bus.sramData, prev_data);
      end
      if (prev_done) chk(!bus.busy, "busy_fall", bus.busy, 0);
      if (bus.sramWe || bus.startRasterizing) chk(bus.busy, "busy_active", bus.busy, 1);
      if (bus.sramWe && bus.sramReady) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_beat", bus.sramAddr, 0);
        end else begin
          e = exp_q.pop_front();
          chk(bus.sramAddr == AB'(e.addr), "beat_addr", bus.sramAddr, e.addr);
          chk(bus.sramData == 16'(e.data), "beat_data", bus.sramData, e.data);
        end
        if (ready_mode == 0 && bi != 0)
          chk(cyc == last_acc_cyc + 1, "tile_back_to_back", cyc - last_acc_cyc, 1);
        if (log_en && log_n < NB) begin
          log_addr[log_n] = bus.sramAddr;
          log_data[log_n] = bus.sramData;
          log_n++;
        end
        bi = (bi + 1) % (T * T);
        acc_total++;
        last_acc_cyc = cyc;
      end
      if (bus.frameDone) begin
        chk(cyc == last_acc_cyc + 1, "done_latency", cyc - last_acc_cyc, 1);
        chk(exp_q.size() == 0, "done_drained", exp_q.size(), 0);
        chk(bus.busy, "busy_at_done", bus.busy, 1);
        done_total++;
      end
      prev_stall = bus.sramWe && !bus.sramReady;
      prev_addr = bus.sramAddr;
      prev_data = bus.sramData;
      prev_done = bus.frameDone;
    end
  end

  task automatic chk_zero(input string tag);
    chk(bus.frameDone == 0, {tag, "_frameDone"}, bus.frameDone, 0);
    chk(bus.busy == 0, {tag, "_busy"}, bus.busy, 0);
    chk(bus.startRasterizing == 0, {tag, "_start"}, bus.startRasterizing, 0);
    chk(bus.rasterxOffset == 0, {tag, "_xoff"}, bus.rasterxOffset, 0);
    chk(bus.rasteryOffset == 0, {tag, "_yoff"}, bus.rasteryOffset, 0);
    chk(bus.rasterTileID == 0, {tag, "_id"}, bus.rasterTileID, 0);
    chk(bus.sramAddr == 0, {tag, "_addr"}, bus.sramAddr, 0);
    chk(bus.sramData == 0, {tag, "_data"}, bus.sramData, 0);
    chk(bus.sramWe == 0, {tag, "_we"}, bus.sramWe, 0);
  endtask

  task automatic run_frame(input bit do_spam);
    int a0, d0, r0, n;
    bit seen;
    @(posedge clk); #1;
    a0 = acc_total; d0 = done_total; r0 = req_total;
    req_base = req_total;
    bus.frameStart = 1'b1;
    @(posedge clk); #1;
    bus.frameStart = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (bus.frameDone) begin
        seen = 1;
        bus.frameStart = do_spam;
      end else begin
        bus.frameStart = do_spam && ($urandom_range(0, 5) == 0);
      end
    end
    chk(seen, "frame_timeout", n, 4000);
    @(posedge clk); #1;
    bus.frameStart = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk(!bus.busy && !bus.startRasterizing, "idle_after_done", {bus.busy, bus.startRasterizing}, 0);
    end
    chk(done_total - d0 == 1, "done_once", done_total - d0, 1);
    chk(acc_total - a0 == NB, "beats_per_frame", acc_total - a0, NB);
    chk(req_total - r0 == NT, "tiles_per_frame", req_total - r0, NT);
  endtask

  initial begin
    int a0, d0, n;
    bus.frameStart = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Deterministic pattern frame with sramReady held high
    pattern_mode = 1; log_en = 1; ready_mode = 0;
    run_frame(0);
    log_en = 0; pattern_mode = 0;
    chk(log_n == NB, "log_count", log_n, NB);
    chk(log_addr[0] == 0 && log_data[0] == 16'h0100, "lit_beat0", log_addr[0], 0);
    chk(log_addr[3] == 3 && log_data[3] == 16'h0103, "lit_beat3", log_addr[3], 3);
    chk(log_addr[4] == 8 && log_data[4] == 16'h0104, "lit_beat4", log_addr[4], 8);
    chk(log_addr[5] == 9 && log_data[5] == 16'h0105, "lit_beat5", log_addr[5], 9);
    chk(log_addr[15] == 27 && log_data[15] == 16'h010F, "lit_beat15", log_addr[15], 27);
    chk(log_addr[16] == 4 && log_data[16] == 16'h0100, "lit_beat16", log_addr[16], 4);
    chk(log_addr[31] == 31 && log_data[31] == 16'h010F, "lit_beat31", log_addr[31], 31);
    chk(log_addr[32] == 32 && log_data[32] == 16'h0100, "lit_beat32", log_addr[32], 32);
    chk(log_addr[63] == 63 && log_data[63] == 16'h010F, "lit_beat63", log_addr[63], 63);

    // Toggling and random stalls, with ignored frameStart pulses
    ready_mode = 1;
    run_frame(0);
    ready_mode = 2;
    repeat (3) run_frame(1);

    // Reset in the middle of a frame
    ready_mode = 2;
    @(posedge clk); #1;
    a0 = acc_total;
    req_base = req_total;
    bus.frameStart = 1'b1;
    @(posedge clk); #1;
    bus.frameStart = 1'b0;
    n = 0;
    while (acc_total - a0 < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(n < 2000, "midreset_timeout", n, 2000);
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (3) @(negedge clk);
    chk_zero("midreset_hold");
    rst_n = 1'b1;
    req_base = req_total;
    repeat (3) @(negedge clk);
    chk(done_total == d0, "midreset_no_done", done_total - d0, 0);
    chk(!bus.busy && !bus.sramWe, "midreset_idle", {bus.busy, bus.sramWe}, 0);

    // Fresh frame after reset must start from tile 0,0
    run_frame(1);
    ready_mode = 0;
    run_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/tile_scheduler_writeback.md
TILE_SCHEDULER_WRITEBACK -- requirements
Module: tile_scheduler_writeback

Interface
REQ-001 Parameter tileDim, default 4: tile edge in pixels; must match the rasterizer.
REQ-002 Parameter screenW, default 640: frame width in pixels; must be a multiple of tileDim.
REQ-003 Parameter screenH, default 480: frame height in pixels; must be a multiple of tileDim.
REQ-004 Parameter addrBits, default 19: framebuffer word-address width.
REQ-005 BOARD_CLK input 1: sole clock; all state updates on its rising edge.
REQ-006 BOARD_RESET_N input 1: asynchronous, active-low reset.
REQ-007 frameStart input 1: one-cycle request to render one frame.
REQ-008 frameDone output 1: one-cycle pulse after the last pixel of the frame has been accepted.
REQ-009 busy output 1: high from frame acceptance until the frameDone cycle, inclusive.
REQ-010 startRasterizing output 1: tile request to the rasterizer, held until doneRasterizing is seen.
REQ-011 doneRasterizing input 1: rasterizer completion, level.
REQ-012 rasterxOffset, rasteryOffset output 10 each: pixel origin of the requested tile.
REQ-013 rasterTileID output 1: colour buffer (0/1) the rasterizer fills.
REQ-014 cBufferTile0, cBufferTile1 input 16 x [tileDim][tileDim]: rasterizer colour tiles, indexed [x][y].
REQ-015 sramAddr output addrBits: framebuffer write address.
REQ-016 sramData output 16: pixel data.
REQ-017 sramWe output 1: write-valid.
REQ-018 sramReady input 1: the beat is accepted in any cycle where sramWe and sramReady are both high.

Function
REQ-019 Tiles SHALL be issued in raster order: x advances by tileDim from 0 to screenW-tileDim; then x wraps to 0 and y advances by tileDim up to screenH-tileDim.
REQ-020 Tile n SHALL use buffer n mod 2, and rasterTileID SHALL restart at 0 for each frame.
REQ-021 Raster FSM states: R_IDLE, R_REQ, R_RELEASE, R_HANDOFF.
- R_IDLE: frameStart -> R_REQ, with offsets 0,0 and ID 0.
- R_REQ: startRasterizing=1; doneRasterizing=1 -> R_RELEASE.
- R_RELEASE: startRasterizing=0; doneRasterizing=0 -> R_HANDOFF.
REQ-022 R_HANDOFF SHALL wait until the writeback FSM is idle; in the same cycle it SHALL:
- start writeback of the just-finished buffer at its offsets;
- if tiles remain, advance the offsets, toggle rasterTileID and go to R_REQ;
- otherwise go to R_IDLE-pending-drain.
REQ-023 Offsets and rasterTileID SHALL remain stable throughout R_REQ.
REQ-024 Writeback FSM states: W_IDLE, W_WRITE.
- W_WRITE SHALL emit tileDim*tileDim beats, with px fastest, then py.
- Beat data is buffer[px][py]; address = (tileY+py)*screenW + tileX + px, truncated to addrBits.
REQ-025 sramAddr, sramData and sramWe SHALL hold unchanged while sramReady is low (no beat drop or duplication).
REQ-026 After the final accepted beat, the FSM SHALL return to W_IDLE in the next cycle; the first beat is presented in the cycle after handoff.
REQ-027 The buffer being written back SHALL never equal rasterTileID while startRasterizing is high.
REQ-028 frameDone SHALL pulse in the cycle after the last beat of the last tile is accepted, and busy SHALL fall one cycle after that.
REQ-029 frameStart while busy=1 SHALL be ignored; frameStart in the frameDone cycle SHALL also be ignored.
REQ-030 When sramReady is held high, each tile SHALL take exactly tileDim*tileDim write cycles.

Reset
REQ-031 While BOARD_RESET_N=0, all outputs SHALL be 0 and both FSMs SHALL be idle; this applies immediately and asynchronously.
REQ-032 Reset mid-frame SHALL abandon the frame and any pending beats with no frameDone; the first frameStart after release starts at tile 0,0.

Verification (screenW=8, screenH=4, tileDim=4 unless stated)
REQ-033 frameStart, rasterizer model done 5 cycles after start, sramReady=1:
- tiles requested in order (0,0,ID0), (4,0,ID1);
- 32 writes to addresses 0-3, 8-11, 16-19, 24-27, then 4-7, 12-15, 20-23, 28-31;
- frameDone pulses once.
REQ-034 cBufferTile0[x][y]=16'h0100+4y+x -> data at address y*8+x equals 16'h0100+4y+x.
REQ-035 sramReady toggled 0/1 per cycle -> exactly 32 accepted beats, with addr/data stable across each stall.
REQ-036 Tile 1 rasterizing finishes while tile 0 writeback is stalled -> R_HANDOFF waits, and startRasterizing stays 0 until W_IDLE.
REQ-037 frameStart during busy -> ignored, with 2 tiles total; BOARD_RESET_N pulsed low at write 10 -> outputs 0 and no frameDone.
REQ-038 screenW=640, screenH=480 -> 19200 tiles, last offset (636,476), last address 307199, single frameDone.
